// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-port data-memory responder with wait states and error flagging
//
// Ports:
//   clk_i        rising-edge clock
//   reset_i      asynchronous active-high reset (storage is not cleared)
//   req_valid_i  request present            req_ready_o  request accepted this cycle (IDLE)
//   req_we_i     1 = write, 0 = read        req_addr_i   byte address
//   req_wdata_i  write data                 req_be_i     write byte enables
//   rsp_valid_o  response present (RESP)    rsp_ready_i  response consumed
//   rsp_rdata_o  read data (0 for writes/errors)
//   rsp_err_o    misaligned or out-of-range request
//   stall_o      combinational pipeline stall to the processor
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [3:0]  req_be_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        stall_o
);

   localparam int AW       = $clog2(DEPTH_WORDS);
   localparam int CNT_INIT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [2:0]  cnt;
   logic [2:0]  cnt_next;

   // Request captured at acceptance; used when the response is formed in a later cycle.
   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;

   logic [31:0] rdata_q;
   logic        err_q;

   logic [31:0] mem [DEPTH_WORDS];

   logic        accept;
   logic        enter_resp;
   logic        leave_resp;

   // Operands for the edge entering RESP. With zero wait states that edge is the
   // acceptance edge itself, so the live request inputs are used instead of the latches.
   logic        cur_we;
   logic [31:0] cur_addr;
   logic [31:0] cur_wdata;
   logic [3:0]  cur_be;
   logic        cur_err;
   logic [AW-1:0] cur_idx;
   logic [31:0] cur_rdata;

   always_comb begin
      cur_we    = (state == IDLE) ? req_we_i    : we_q;
      cur_addr  = (state == IDLE) ? req_addr_i  : addr_q;
      cur_wdata = (state == IDLE) ? req_wdata_i : wdata_q;
      cur_be    = (state == IDLE) ? req_be_i    : be_q;
      // DEPTH_WORDS is a power of two, so addr[31:2] >= DEPTH_WORDS is any bit set above the index.
      cur_err   = (cur_addr[1:0] != 2'b00) || (cur_addr[31:AW+2] != '0);
      cur_idx   = cur_addr[AW+1:2];
      cur_rdata = mem[cur_idx];
   end

   // Next-state and outputs
   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      accept      = 1'b0;
      enter_resp  = 1'b0;
      leave_resp  = 1'b0;
      req_ready_o = 1'b0;
      rsp_valid_o = 1'b0;
      stall_o     = 1'b1;

      case (state)
         IDLE: begin
            req_ready_o = 1'b1;
            stall_o     = req_valid_i;
            if (req_valid_i) begin
               accept = 1'b1;
               if (WAIT_CYCLES > 0) begin
                  state_next = WAIT;
                  cnt_next   = 3'(CNT_INIT);
               end else begin
                  state_next = RESP;
                  enter_resp = 1'b1;
               end
            end
         end
         WAIT: begin
            if (cnt == 3'd0) begin
               state_next = RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_next = cnt - 3'd1;
            end
         end
         RESP: begin
            rsp_valid_o = 1'b1;
            // The processor may proceed in the same cycle it consumes the response.
            stall_o     = ~rsp_ready_i;
            if (rsp_ready_i) begin
               state_next = IDLE;
               leave_resp = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state   <= IDLE;
         cnt     <= 3'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         be_q    <= 4'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (accept) begin
            we_q    <= req_we_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            be_q    <= req_be_i;
         end
         if (enter_resp) begin
            rdata_q <= (cur_err || cur_we) ? 32'h0 : cur_rdata;
            err_q   <= cur_err;
         end else if (leave_resp) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
         end
      end
   end

   // Storage has no reset. The reset_i gate keeps an edge that lands while reset is
   // held from committing a write that the control path is discarding.
   always_ff @(posedge clk_i) begin
      if (!reset_i && enter_resp && cur_we && !cur_err) begin
         for (int b = 0; b < 4; b++) begin
            if (cur_be[b]) begin
               mem[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
            end
         end
      end
   end

   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder at WAIT_CYCLES 1, 0 and 3
module tb_dmem_responder;

   localparam int N = 3;   // instance 0: WAIT_CYCLES=1, 1: WAIT_CYCLES=0, 2: WAIT_CYCLES=3

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst       [N];
   logic        req_valid [N];
   logic        req_ready [N];
   logic        req_we    [N];
   logic [31:0] req_addr  [N];
   logic [31:0] req_wdata [N];
   logic [3:0]  req_be    [N];
   logic        rsp_valid [N];
   logic        rsp_ready [N];
   logic [31:0] rsp_rdata [N];
   logic        rsp_err   [N];
   logic        stall     [N];

   for (genvar g = 0; g < N; g++) begin : g_dut
      dmem_responder #(
         .DEPTH_WORDS(256),
         .WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 0 : 3))
      ) u_dut (
         .clk_i      (clk),
         .reset_i    (rst[g]),
         .req_valid_i(req_valid[g]),
         .req_ready_o(req_ready[g]),
         .req_we_i   (req_we[g]),
         .req_addr_i (req_addr[g]),
         .req_wdata_i(req_wdata[g]),
         .req_be_i   (req_be[g]),
         .rsp_valid_o(rsp_valid[g]),
         .rsp_ready_i(rsp_ready[g]),
         .rsp_rdata_o(rsp_rdata[g]),
         .rsp_err_o  (rsp_err[g]),
         .stall_o    (stall[g])
      );
   end

   typedef struct {
      int          d;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] mdl [N][256];
   int          total = 0;
   int          bad   = 0;

   function automatic int wc(input int d);
      return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
   endfunction

   // One full request/response on instance d; hold = cycles of rsp_ready=0 in RESP.
   task automatic transact(input int d, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           input int hold, input string name);
      exp_t e;
      exp_t got;
      logic err;
      int   edges;
      err     = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'd256);
      e.d     = d;
      e.err   = err;
      e.rdata = (err || we) ? 32'h0 : mdl[d][addr[9:2]];
      sb.push_back(e);
      if (!err && we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mdl[d][addr[9:2]][8*b +: 8] = wdata[8*b +: 8];
         end
      end

      @(negedge clk);
      total++;
      if (req_ready[d] !== 1'b1) begin
         bad++;
         $display("FAIL %s idle_ready: got %b want 1", name, req_ready[d]);
      end
      req_valid[d] = 1'b1;
      req_we[d]    = we;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      req_be[d]    = be;
      rsp_ready[d] = (hold == 0);
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      // Request inputs now carry junk; it must be ignored until the next acceptance.
      req_we[d]    = 1'($urandom_range(0, 1));
      req_addr[d]  = $urandom;
      req_wdata[d] = $urandom;
      req_be[d]    = 4'($urandom);
      while (rsp_valid[d] !== 1'b1 && edges < 20) begin
         total++;
         if ({req_ready[d], stall[d]} !== 2'b01) begin
            bad++;
            $display("FAIL %s wait_ready_stall: got %b%b want 01", name, req_ready[d], stall[d]);
         end
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      total++;
      if (rsp_valid[d] !== 1'b1 || edges != wc(d) + 1) begin
         bad++;
         $display("FAIL %s latency: got valid=%b edges=%0d want valid=1 edges=%0d",
                  name, rsp_valid[d], edges, wc(d) + 1);
      end
      for (int i = 0; i < hold; i++) begin
         total++;
         if ({rsp_valid[d], stall[d], req_ready[d], rsp_err[d], rsp_rdata[d]} !==
             {1'b1, 1'b1, 1'b0, e.err, e.rdata}) begin
            bad++;
            $display("FAIL %s held: got v=%b s=%b r=%b e=%b d=%h want v=1 s=1 r=0 e=%b d=%h",
                     name, rsp_valid[d], stall[d], req_ready[d], rsp_err[d], rsp_rdata[d],
                     e.err, e.rdata);
         end
         @(posedge clk);
         @(negedge clk);
      end
      rsp_ready[d] = 1'b1;
      #1;
      total++;
      if (stall[d] !== 1'b0) begin
         bad++;
         $display("FAIL %s stall_on_consume: got %b want 0", name, stall[d]);
      end
      got = sb.pop_front();
      total++;
      if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== got.rdata || rsp_err[d] !== got.err) begin
         bad++;
         $display("FAIL %s response: got v=%b rdata=%h err=%b want v=1 rdata=%h err=%b",
                  name, rsp_valid[d], rsp_rdata[d], rsp_err[d], got.rdata, got.err);
      end
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({rsp_valid[d], req_ready[d]} !== 2'b01) begin
         bad++;
         $display("FAIL %s after_resp: got v=%b r=%b want v=0 r=1", name, rsp_valid[d], req_ready[d]);
      end
      req_valid[d] = 1'b0;
      rsp_ready[d] = 1'b0;
   endtask

   task automatic test_reset;
      for (int d = 0; d < N; d++) begin
         rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'h0;
         req_wdata[d] = 32'h0; req_be[d] = 4'h0; rsp_ready[d] = 1'b0;
      end
      #2;
      for (int d = 0; d < N; d++) begin
         total++;
         if ({rsp_valid[d], req_ready[d], rsp_err[d], stall[d], rsp_rdata[d]} !==
             {1'b0, 1'b1, 1'b0, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL reset_state[%0d]: got v=%b r=%b e=%b s=%b d=%h want v=0 r=1 e=0 s=0 d=0",
                     d, rsp_valid[d], req_ready[d], rsp_err[d], stall[d], rsp_rdata[d]);
         end
      end
      @(negedge clk);
      for (int d = 0; d < N; d++) rst[d] = 1'b0;
   endtask

   task automatic test_basic;
      transact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, "wr_10");
      transact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, "rd_10");
   endtask

   task automatic test_byte_enables;
      transact(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, "wr_20_full");
      transact(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, "wr_20_be5");
      transact(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, "rd_20_merged");
      transact(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0, "wr_20_be0");
      transact(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, "rd_20_after_be0");
   endtask

   task automatic test_errors;
      transact(0, 1'b1, 32'h000, 32'h55AA55AA, 4'hF, 0, "wr_000");
      transact(0, 1'b1, 32'h3FC, 32'h0F0F1234, 4'hF, 0, "wr_last");
      transact(0, 1'b0, 32'h013, 32'h0, 4'h0, 0, "rd_misaligned");
      transact(0, 1'b1, 32'h400, 32'h99999999, 4'hF, 0, "wr_out_of_range");
      transact(0, 1'b1, 32'h002, 32'h77777777, 4'hF, 0, "wr_misaligned");
      transact(0, 1'b0, 32'h000, 32'h0, 4'h0, 0, "rd_000_unchanged");
      transact(0, 1'b0, 32'h3FC, 32'h0, 4'h0, 0, "rd_last");
      transact(0, 1'b0, 32'h400, 32'h0, 4'h0, 0, "rd_out_of_range");
   endtask

   task automatic test_backpressure;
      transact(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, "rd_10_backpressure");
      transact(0, 1'b1, 32'h24, 32'h01234567, 4'hF, 3, "wr_24_backpressure");
   endtask

   task automatic test_back_to_back;
      exp_t e0;
      exp_t e1;
      exp_t got;
      transact(1, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 0, "w0_wr_0");
      transact(1, 1'b1, 32'h4, 32'h12345678, 4'hF, 0, "w0_wr_4");
      e0.d = 1; e0.rdata = mdl[1][0]; e0.err = 1'b0; sb.push_back(e0);
      e1.d = 1; e1.rdata = mdl[1][1]; e1.err = 1'b0; sb.push_back(e1);
      @(negedge clk);
      rsp_ready[1] = 1'b1;
      req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h0;
      @(posedge clk);
      @(negedge clk);
      got = sb.pop_front();
      total++;
      if ({rsp_valid[1], rsp_err[1], rsp_rdata[1]} !== {1'b1, got.err, got.rdata}) begin
         bad++;
         $display("FAIL b2b_first: got v=%b e=%b d=%h want v=1 e=%b d=%h",
                  rsp_valid[1], rsp_err[1], rsp_rdata[1], got.err, got.rdata);
      end
      req_addr[1] = 32'h4;
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({rsp_valid[1], req_ready[1]} !== 2'b01) begin
         bad++;
         $display("FAIL b2b_gap: got v=%b r=%b want v=0 r=1", rsp_valid[1], req_ready[1]);
      end
      @(posedge clk);
      @(negedge clk);
      got = sb.pop_front();
      total++;
      if ({rsp_valid[1], rsp_err[1], rsp_rdata[1]} !== {1'b1, got.err, got.rdata}) begin
         bad++;
         $display("FAIL b2b_second: got v=%b e=%b d=%h want v=1 e=%b d=%h",
                  rsp_valid[1], rsp_err[1], rsp_rdata[1], got.err, got.rdata);
      end
      req_valid[1] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      total++;
      if (rsp_valid[1] !== 1'b0) begin
         bad++;
         $display("FAIL b2b_drain: got v=%b want 0", rsp_valid[1]);
      end
      rsp_ready[1] = 1'b0;
   endtask

   task automatic test_reset_mid_wait;
      transact(2, 1'b1, 32'h8, 32'h01020304, 4'hF, 0, "w3_wr_8");
      @(negedge clk);
      rsp_ready[2] = 1'b1;
      req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h8;
      req_wdata[2] = 32'hCAFEF00D; req_be[2] = 4'hF;
      @(posedge clk);
      @(negedge clk);
      req_valid[2] = 1'b0;
      total++;
      if ({rsp_valid[2], req_ready[2]} !== 2'b00) begin
         bad++;
         $display("FAIL mid_wait_state: got v=%b r=%b want v=0 r=0", rsp_valid[2], req_ready[2]);
      end
      #2 rst[2] = 1'b1;
      #1;
      total++;
      if ({rsp_valid[2], req_ready[2], rsp_err[2], stall[2], rsp_rdata[2]} !==
          {1'b0, 1'b1, 1'b0, 1'b0, 32'h0}) begin
         bad++;
         $display("FAIL async_reset: got v=%b r=%b e=%b s=%b d=%h want v=0 r=1 e=0 s=0 d=0",
                  rsp_valid[2], req_ready[2], rsp_err[2], stall[2], rsp_rdata[2]);
      end
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst[2] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         total++;
         if (rsp_valid[2] !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_quiet[%0d]: got v=%b want 0", i, rsp_valid[2]);
         end
      end
      rsp_ready[2] = 1'b0;
      transact(2, 1'b0, 32'h8, 32'h0, 4'h0, 0, "w3_rd_8_old");
      transact(2, 1'b0, 32'h3, 32'h0, 4'h0, 2, "w3_rd_misaligned");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_byte_enables();
      test_errors();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_wait();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
